mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified RAM of the multi-cycle CPU between the CPU and a DMA/debug loader.
//  Sits between both requesters and the ram instance, and muxes addr/wdata/we onto the RAM.
//  The CPU has fixed priority. DMA bursts are locked up to a limit, and a starvation counter guarantees DMA progress.
//  cpu_stall tells the CPU control unit to hold its current state.
// PARAMETERS
//  ADDR_W       32  address width, both requesters and RAM
//  DATA_W       32  data width
//  MAX_BURST    8   max DMA beats per locked burst (>=1)
//  STARVE_LIMIT 16  consecutive denied DMA cycles before DMA wins one arbitration (>=1)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  cpu_req      in   1       CPU access request; addr/we/wdata held stable until granted
//  cpu_we       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  CPU byte address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_gnt      out  1       access performed this cycle (comb)
//  cpu_stall    out  1       cpu_req & ~cpu_gnt (comb)
//  cpu_rvalid   out  1       read data valid, 1 cycle after a granted read
//  cpu_rdata    out  DATA_W  registered read data
//  dma_req/we/addr/wdata     as the CPU ports, for the DMA requester
//  dma_last     in   1       current beat is the last beat of the burst
//  dma_gnt      out  1       DMA access performed this cycle (comb)
//  dma_rvalid   out  1       as cpu_rvalid
//  dma_rdata    out  DATA_W  as cpu_rdata
//  mem_addr     out  ADDR_W  to RAM addr
//  mem_wdata    out  DATA_W  to RAM w_data
//  mem_we       out  1       to RAM we
//  mem_rdata    in   DATA_W  RAM asynchronous read data
//  stat_cpu_stall out 32     CPU stall-cycle count (see CONFIGURATION)
//  stat_dma_beats out 32     DMA granted-beat count
// BEHAVIOUR
//  - Transfer happens in a cycle where req&gnt=1. At most one gnt is high per cycle.
//    mem_* are driven combinationally from the granted requester.
//    With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
//  - mem_we = gnt & we of the granted requester. A granted write produces no rvalid.
//  - Granted read: mem_rdata is registered into x_rdata, and x_rvalid pulses for exactly 1 cycle next cycle.
//    x_rdata holds its value until the next granted read.
//  - FSM ArbIdle:
//    - cpu_req -> cpu_gnt, unless starve_cnt==STARVE_LIMIT with dma_req high, in which case dma_gnt.
//    - Otherwise dma_req -> dma_gnt.
//    - DMA granted with ~dma_last and MAX_BURST>1 -> ArbDma, beat_cnt=1.
//  - FSM ArbDma: cpu_gnt=0, dma_gnt=dma_req, beat_cnt++ per granted beat. Return to ArbIdle when:
//    - a granted beat has dma_last, or
//    - a granted beat makes beat_cnt==MAX_BURST (forced release; DMA re-arbitrates), or
//    - dma_req is low for a cycle (burst aborted; no gnt that cycle).
//  - starve_cnt increments each cycle with dma_req&~dma_gnt, saturating at STARVE_LIMIT.
//    It clears on any dma_gnt or when dma_req drops.
//  - Simultaneous cpu_req and dma_req in ArbIdle with no starvation: CPU wins, and the DMA request stays pending.
//  - reset_n low (any time, including mid-burst): state=ArbIdle; beat_cnt, starve_cnt=0;
//    all gnt/rvalid=0, rdata=0, stats=0. A pending rvalid is dropped.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined:
//    stat_cpu_stall counts cycles with cpu_stall=1; stat_dma_beats counts dma_gnt cycles.
//    Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on reset.
//  Not defined: no counter flops; both stat ports are tied to 0. The port list is unchanged.
// STRUCTURE
//  Shared package MemArbPkg holds:
//    - typedef enum logic {ArbIdle, ArbDma} arb_state_e
//    - typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} arb_owner_e
//  Sub-module mem_arb_rsp_reg, instantiated twice (CPU, DMA):
//    inputs clk, reset_n, capture (gnt&~we), mem_rdata; outputs rvalid, rdata.
// TESTING
//  1 CPU read 0x40 alone (RAM[0x40]=0xDEADBEEF) -> cpu_gnt same cycle, cpu_rvalid+rdata=0xDEADBEEF next cycle, stall=0.
//  2 cpu_req and dma_req both high in ArbIdle -> cpu_gnt=1, dma_gnt=0; DMA granted in the first cycle with cpu_req=0.
//  3 DMA 4-beat write burst 0x100..0x10C, dma_last on beat 4, CPU requests from beat 2 ->
//    all 4 DMA beats consecutive, cpu_stall=1 for 3 cycles, CPU granted in cycle 5.
//  4 DMA 12-beat burst with MAX_BURST=8 and CPU waiting -> release after beat 8, one CPU grant, then DMA resumes.
//  5 cpu_req held high with dma_req high, STARVE_LIMIT=16 -> dma_gnt in cycle 17, then CPU again; starve_cnt back to 0.
//  6 reset_n low during beat 3 of a DMA burst -> all gnt/rvalid 0 immediately, state ArbIdle;
//    with MEM_ARB_STATS_EN, stats read 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the CPU/DMA memory port arbiter.
// Optional statistics counters are enabled with the MEM_ARB_STATS_EN macro.
package MemArbPkg;

    typedef enum logic {ArbIdle, ArbDma} arb_state_e;

    typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} arb_owner_e;

    localparam logic [31:0] StatMax = 32'hFFFF_FFFF;

    // Saturating increment used by the statistics counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == StatMax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp.sv
// Read-response register for one requester: captures RAM read data on a
// granted read and raises rvalid for exactly the following cycle.
module mem_arb_rsp_reg
    import MemArbPkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // Capture read data; rdata holds until the next granted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= capture;
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for the single-port unified RAM. CPU has fixed priority,
// DMA bursts are locked up to MAX_BURST beats and a starvation counter forces
// a DMA win after STARVE_LIMIT denied cycles.
// Define MEM_ARB_STATS_EN to build the stall/beat statistics counters.
module mem_port_arbiter
    import MemArbPkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       stat_cpu_stall,
    output logic [31:0]       stat_dma_beats
);

    localparam int unsigned BeatW   = $clog2(MAX_BURST + 1);
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    arb_state_e         state_q, state_d;
    arb_owner_e         owner;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               dma_starved;

    assign dma_starved = (starve_q == StarveW'(STARVE_LIMIT));

    // Arbitration, burst lock and starvation tracking.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        owner    = OwnNone;
        unique case (state_q)
            ArbIdle: begin
                if (cpu_req && !(dma_starved && dma_req)) begin
                    owner = OwnCpu;
                end else if (dma_req) begin
                    owner = OwnDma;
                end
                if (owner == OwnDma && !dma_last && MAX_BURST > 1) begin
                    state_d = ArbDma;
                    beat_d  = BeatW'(1);
                end
            end
            ArbDma: begin
                if (dma_req) begin
                    owner  = OwnDma;
                    beat_d = beat_q + BeatW'(1);
                    if (dma_last || (beat_q + BeatW'(1) == BeatW'(MAX_BURST))) begin
                        state_d = ArbIdle;
                        beat_d  = '0;
                    end
                end else begin
                    // Burst aborted by the DMA dropping its request.
                    state_d = ArbIdle;
                    beat_d  = '0;
                end
            end
            default: state_d = ArbIdle;
        endcase
        // Grants are suppressed while reset is asserted.
        if (!reset_n) begin
            owner = OwnNone;
        end
        if (dma_req && owner != OwnDma) begin
            starve_d = dma_starved ? starve_q : starve_q + StarveW'(1);
        end else begin
            starve_d = '0;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ArbIdle;
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    assign cpu_gnt   = (owner == OwnCpu);
    assign dma_gnt   = (owner == OwnDma);
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // RAM port mux driven from the granted requester; idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (owner)
            OwnCpu: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            OwnDma: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we;
            end
            default: ;
        endcase
    end

    mem_arb_rsp_reg #(
        .DATA_W(DATA_W)
    ) u_cpu_rsp (
        .clk      (clk),
        .reset_n  (reset_n),
        .capture  (cpu_gnt & ~cpu_we),
        .mem_rdata(mem_rdata),
        .rvalid   (cpu_rvalid),
        .rdata    (cpu_rdata)
    );

    mem_arb_rsp_reg #(
        .DATA_W(DATA_W)
    ) u_dma_rsp (
        .clk      (clk),
        .reset_n  (reset_n),
        .capture  (dma_gnt & ~dma_we),
        .mem_rdata(mem_rdata),
        .rvalid   (dma_rvalid),
        .rdata    (dma_rdata)
    );

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stall_q;
    logic [31:0] stat_dma_beats_q;

    // Saturating stall-cycle and DMA-beat counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpu_stall_q <= '0;
            stat_dma_beats_q <= '0;
        end else begin
            if (cpu_stall) begin
                stat_cpu_stall_q <= sat_inc32(stat_cpu_stall_q);
            end
            if (dma_gnt) begin
                stat_dma_beats_q <= sat_inc32(stat_dma_beats_q);
            end
        end
    end

    assign stat_cpu_stall = stat_cpu_stall_q;
    assign stat_dma_beats = stat_dma_beats_q;
`else
    assign stat_cpu_stall = '0;
    assign stat_dma_beats = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small RAM model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [31:0] stat_cpu_stall, stat_dma_beats;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ram [0:511];

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_BURST   (8),
        .STARVE_LIMIT(16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_gnt       (cpu_gnt),
        .cpu_stall     (cpu_stall),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_last      (dma_last),
        .dma_gnt       (dma_gnt),
        .dma_rvalid    (dma_rvalid),
        .dma_rdata     (dma_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .stat_cpu_stall(stat_cpu_stall),
        .stat_dma_beats(stat_dma_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: preloaded words at 0x40 and 0x80, synchronous write.
    always_comb begin
        if (mem_addr == 32'h40)      mem_rdata = 32'hDEAD_BEEF;
        else if (mem_addr == 32'h80) mem_rdata = 32'h1234_5678;
        else                         mem_rdata = ram[mem_addr[10:2]];
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[10:2]] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic last);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; dma_last = last;
    endtask

    initial begin
        reset_n = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        check("rst_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_stat_stall", stat_cpu_stall, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: lone CPU read of 0x40
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        settle();
        check("t1_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check("t1_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_mem_we", {31'b0, mem_we}, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        check("t1_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        settle();
        check("t1_idle_mem_addr", mem_addr, 32'd0);
        tick();
        check("t1_rvalid_drop", {31'b0, cpu_rvalid}, 32'd0);
        check("t1_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // 2: simultaneous requests, CPU wins, DMA granted once CPU drops
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        set_dma(1'b1, 1'b0, 32'h80, 32'h0, 1'b1);
        settle();
        check("t2_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check("t2_dma_gnt_low", {31'b0, dma_gnt}, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t2_dma_gnt", {31'b0, dma_gnt}, 32'd1);
        check("t2_mem_addr", mem_addr, 32'h80);
        check("t2_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        tick();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("t2_dma_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check("t2_dma_rdata", dma_rdata, 32'h1234_5678);
        check("t2_cpu_rvalid_drop", {31'b0, cpu_rvalid}, 32'd0);

        // 3: 4-beat DMA write burst, CPU requests from beat 2
        for (int i = 0; i < 4; i++) begin
            set_dma(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), (i == 3));
            if (i >= 1) set_cpu(1'b1, 1'b1, 32'h200, 32'hC0);
            settle();
            check("t3_dma_gnt", {31'b0, dma_gnt}, 32'd1);
            check("t3_mem_we", {31'b0, mem_we}, 32'd1);
            check("t3_cpu_stall", {31'b0, cpu_stall}, (i >= 1) ? 32'd1 : 32'd0);
            tick();
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("t3_cpu_gnt_c5", {31'b0, cpu_gnt}, 32'd1);
        check("t3_cpu_stall_c5", {31'b0, cpu_stall}, 32'd0);
        check("t3_mem_addr_c5", mem_addr, 32'h200);
        check("t3_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        check("t3_ram_100", ram[64], 32'hA0);
        check("t3_ram_10c", ram[67], 32'hA3);
        check("t3_ram_200", ram[128], 32'hC0);
        check("t3_cpu_rvalid_wr", {31'b0, cpu_rvalid}, 32'd0);
        check("t3_stat_stall", stat_cpu_stall, StatsOn ? 32'd3 : 32'd0);
        check("t3_stat_beats", stat_dma_beats, StatsOn ? 32'd5 : 32'd0);

        // 4: 12-beat burst, forced release after beat 8, one CPU grant
        for (int i = 0; i < 8; i++) begin
            set_dma(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0);
            if (i >= 1) set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
            settle();
            check("t4_dma_beat", {31'b0, dma_gnt}, 32'd1);
            check("t4_cpu_held", {31'b0, cpu_gnt}, 32'd0);
            tick();
        end
        set_dma(1'b1, 1'b1, 32'h320, 32'd8, 1'b0);
        settle();
        check("t4_cpu_gnt_release", {31'b0, cpu_gnt}, 32'd1);
        check("t4_dma_gnt_release", {31'b0, dma_gnt}, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        check("t4_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        for (int i = 8; i < 12; i++) begin
            set_dma(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'(i), (i == 11));
            settle();
            check("t4_dma_resume", {31'b0, dma_gnt}, 32'd1);
            tick();
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("t4_dma_done", {31'b0, dma_gnt}, 32'd0);
        check("t4_ram_32c", ram[203], 32'd11);
        check("t4_stat_stall", stat_cpu_stall, StatsOn ? 32'd10 : 32'd0);
        check("t4_stat_beats", stat_dma_beats, StatsOn ? 32'd17 : 32'd0);
        tick();

        // 5: starvation, DMA wins cycle 17, counter restarts
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        set_dma(1'b1, 1'b0, 32'h80, 32'h0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 17; c++) begin
                settle();
                check("t5_cpu_gnt", {31'b0, cpu_gnt}, (c == 17) ? 32'd0 : 32'd1);
                check("t5_dma_gnt", {31'b0, dma_gnt}, (c == 17) ? 32'd1 : 32'd0);
                tick();
            end
        end
        settle();
        check("t5_cpu_after", {31'b0, cpu_gnt}, 32'd1);
        check("t5_stat_stall", stat_cpu_stall, StatsOn ? 32'd12 : 32'd0);
        check("t5_stat_beats", stat_dma_beats, StatsOn ? 32'd19 : 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // 6: reset during beat 3 of a DMA read burst
        for (int i = 0; i < 3; i++) begin
            set_dma(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 1'b0);
            settle();
            check("t6_dma_beat", {31'b0, dma_gnt}, 32'd1);
            if (i < 2) tick();
        end
        check("t6_rvalid_pending", {31'b0, dma_rvalid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        check("t6_rst_mem_addr", mem_addr, 32'd0);
        check("t6_rst_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        check("t6_rst_dma_rdata", dma_rdata, 32'd0);
        check("t6_rst_cpu_rdata", cpu_rdata, 32'd0);
        check("t6_rst_stat_stall", stat_cpu_stall, 32'd0);
        check("t6_rst_stat_beats", stat_dma_beats, 32'd0);
        tick();
        reset_n = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        settle();
        check("t6_idle_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check("t6_idle_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
